nes_pad_responder: RTL and testbench
====================================

# nes_pad_responder

Responder end of the NES controller serial protocol, emulating the 4021-based standard pad. Takes eight local button inputs, debounces them, and answers an external console's strobe/clock with serial button data on a single active-low line. It lets a board act as a controller for a real console, or for a second NES core instance driving `joy_strobe`/`joy_clock`. All inputs may be asynchronous to `clock`.

## Interface
- `FILT`, default 3: consecutive equal samples required before a strobe or clock level change is accepted (glitch filter, ≥1).
- `DEB_CYCLES`, default 65536: cycles a raw button must be stable before its debounced state changes (≥2).
- `clock` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pad_strobe` in 1: latch from console; high = parallel load.
- `pad_clock` in 1: shift clock from console; shifts on the accepted rising edge.
- `buttons` in 8: raw buttons, active-high pressed. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- `pad_data` out 1: serial line to console, active-low (0 = pressed), registered.
- `pad_state` out 8: debounced button state, active-high.
- `bit_count` out 4: bits shifted since strobe fell, saturates at 8.
- `frame_done` out 1: one-cycle pulse when `bit_count` reaches 8.

## Operation
- Each of `pad_strobe`, `pad_clock` and `buttons[i]` passes through a 2-flop synchronizer.
- Strobe and clock filter: the filtered level changes only after `FILT` consecutive identical synchronized samples that differ from the current filtered level.
- Button debounce: per-button counter, restarted on any raw change. `pad_state[i]` takes the raw value when the counter reaches `DEB_CYCLES`.
- While filtered strobe is high:
  - the 8-bit shift register loads `~pad_state` every cycle;
  - `pad_data` = `~pad_state[0]`;
  - `bit_count` = 0;
  - clock edges are ignored.
- On the falling edge of filtered strobe, the register freezes with the last loaded value.
- On each rising edge of filtered clock while filtered strobe is low:
  - the register shifts toward bit 0, and bit 7 fills with 0 (wire low, read as 1 by the console, matching an official pad);
  - `pad_data` = new bit 0;
  - `bit_count` increments, saturating at 8.
- `frame_done` pulses on the 7→8 transition only. Further clocks keep shifting zeros with no pulse.
- Falling edges of filtered clock have no effect.
- Priority rule: if the filtered strobe is high in a cycle, or falls in that cycle, a clock rising edge detected in the same cycle is discarded.
- A new strobe mid-frame (`bit_count` < 8) reloads and clears `bit_count`. No `frame_done` is generated for the aborted frame.

## Timing
- Reset values:
  - shift register 8'hFF;
  - `pad_data` 1;
  - `pad_state` 0;
  - `bit_count` 0;
  - `frame_done` 0;
  - filtered strobe and clock levels 0;
  - debounce counters 0.
- Strobe or clock pin change, stable thereafter, to `pad_data` update: exactly `FILT`+3 cycles (2 sync, `FILT` filter, 1 output register).
- While strobe is held high, a `pad_state` change reaches `pad_data` 1 cycle later.
- Console timing contract: `pad_data` must be valid before the console samples it on the falling edge of its clock. With the defaults, the pad clock high or low phase must be ≥ `FILT`+3 system cycles.
- Pulses shorter than `FILT` cycles are rejected entirely.
- Asserting `reset_n` low mid-frame immediately forces all reset values. Operation resumes on the first clock after release, with the filters starting from level 0.

## Structure
- Shared package `nes_pad_pkg`:
  - button index constants (`BTN_A`…`BTN_RIGHT`);
  - `PAD_BITS` = 8;
  - default `FILT`.
- Sub-module `pin_filter`: 2-flop synchronizer plus stable-count filter with parameter `CYCLES`.
  - One instance each for strobe and clock (`CYCLES`=`FILT`).
  - Eight instances for the buttons (`CYCLES`=`DEB_CYCLES`).
- The top level holds the edge detectors, shift register, bit counter and `frame_done` logic.

## Test plan
- Reset with buttons=8'h00, then release `reset_n` → `pad_data`=1, `bit_count`=0, `frame_done`=0, `pad_state`=0.
- `buttons`=8'b1000_1001 (A, Start, Right) held past `DEB_CYCLES` (=8 in bench), then strobe pulse, then 8 clocks → `pad_data` sequence 0,1,1,0,1,1,1,0. `frame_done` pulses once, with the 8th shift. Clocks 9 and 10 → `pad_data`=0 with no pulse.
- Glitch of `FILT`−1 cycles on `pad_clock` after strobe → no shift, `bit_count` stays 0. A glitch of exactly `FILT` cycles → one shift.
- Strobe re-asserted after 3 clocks → `bit_count`=0, `pad_data`=A bit, and no `frame_done` for the aborted frame.
- Strobe falls in the same cycle a clock rise is accepted → no shift, `bit_count`=0.
- Button bouncing every 3 cycles with `DEB_CYCLES`=8 → `pad_state` unchanged. Once the button is stable, `pad_state` updates exactly after 8 stable cycles. `reset_n` pulsed low mid-frame → all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/nes_pad_pkg.sv
// Shared constants for the NES pad responder: button bit positions and defaults.
package nes_pad_pkg;

  localparam int unsigned PAD_BITS     = 8;
  localparam int unsigned FILT_DEFAULT = 3;
  localparam int unsigned DEB_DEFAULT  = 65536;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/pin_filter.sv
// Two-flop synchronizer followed by a stable-count filter: the output level
// follows the synchronized pin only after CYCLES consecutive differing samples.
module pin_filter #(
  parameter int unsigned CYCLES = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Count the current run of samples that disagree with the level; a run of
  // CYCLES flips the level, any agreeing sample restarts the count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(CYCLES - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nes_pad_responder.sv
// Responder side of the NES controller serial link (4021-style pad): filters
// the console strobe/clock, debounces the buttons and shifts out active-low data.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int unsigned FILT       = FILT_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pad_strobe,
  input  logic                pad_clock,
  input  logic [PAD_BITS-1:0] buttons,
  output logic                pad_data,
  output logic [PAD_BITS-1:0] pad_state,
  output logic [3:0]          bit_count,
  output logic                frame_done
);

  logic                strobe_f;
  logic                clock_f;
  logic                strobe_q;
  logic                clock_q;
  logic                strobe_fall_c;
  logic                clock_rise_c;
  logic [PAD_BITS-1:0] shift_reg;

  pin_filter #(.CYCLES(FILT)) u_strobe (
    .clock  (clock),
    .reset_n(reset_n),
    .pin    (pad_strobe),
    .level  (strobe_f)
  );

  pin_filter #(.CYCLES(FILT)) u_clock (
    .clock  (clock),
    .reset_n(reset_n),
    .pin    (pad_clock),
    .level  (clock_f)
  );

  for (genvar i = 0; i < PAD_BITS; i++) begin : g_btn
    pin_filter #(.CYCLES(DEB_CYCLES)) u_btn (
      .clock  (clock),
      .reset_n(reset_n),
      .pin    (buttons[i]),
      .level  (pad_state[i])
    );
  end

  // Previous filtered levels for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      clock_q  <= 1'b0;
    end else begin
      strobe_q <= strobe_f;
      clock_q  <= clock_f;
    end
  end

  assign strobe_fall_c = strobe_q & ~strobe_f;
  assign clock_rise_c  = clock_f & ~clock_q;

  // Parallel load while strobed; shift on clock rises once strobe is low.
  // A clock rise coinciding with strobe high or its falling edge is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '1;
      pad_data   <= 1'b1;
      bit_count  <= 4'd0;
      frame_done <= 1'b0;
    end else if (strobe_f) begin
      shift_reg  <= ~pad_state;
      pad_data   <= ~pad_state[BTN_A];
      bit_count  <= 4'd0;
      frame_done <= 1'b0;
    end else if (!strobe_fall_c && clock_rise_c) begin
      shift_reg  <= {1'b0, shift_reg[PAD_BITS-1:1]};
      pad_data   <= shift_reg[1];
      if (bit_count != 4'(PAD_BITS)) begin
        bit_count <= bit_count + 4'd1;
      end
      frame_done <= (bit_count == 4'(PAD_BITS - 1));
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Bench for nes_pad_responder: random button patterns read out over the serial
// link and checked against a sliding-window debounce model and pad rules.
module tb_nes_pad_responder;

  localparam int unsigned FILT   = 3;
  localparam int unsigned DEB    = 8;
  localparam int unsigned SETTLE = FILT + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pad_strobe = 1'b0;
  logic       pad_clock = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       pad_data;
  logic [7:0] pad_state;
  logic [3:0] bit_count;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;

  logic [7:0] exp_state;
  logic [7:0] hist [0:DEB+1];

  always #5 clk = ~clk;

  nes_pad_responder #(.FILT(FILT), .DEB_CYCLES(DEB)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .pad_strobe(pad_strobe),
    .pad_clock (pad_clock),
    .buttons   (buttons),
    .pad_data  (pad_data),
    .pad_state (pad_state),
    .bit_count (bit_count),
    .frame_done(frame_done)
  );

  // frame_done pulse counter, sampled mid-cycle
  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  // Debounce model: a button state flips at an edge when the DEB raw samples
  // taken two to DEB+1 edges earlier all disagree with the current state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DEB + 1; j++) hist[j] = 8'h00;
      exp_state = 8'h00;
    end else begin
      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = buttons;
      for (int b = 0; b < 8; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int w = 2; w <= DEB + 1; w++)
          if (hist[w][b] == exp_state[b]) all_diff = 1'b0;
        if (all_diff) exp_state[b] = ~exp_state[b];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_pulse();
    pad_strobe = 1'b1;
    cyc(SETTLE);
    pad_strobe = 1'b0;
    cyc(SETTLE);
  endtask

  task automatic clk_pulse();
    pad_clock = 1'b1;
    cyc(SETTLE);
    pad_clock = 1'b0;
    cyc(SETTLE);
  endtask

  task automatic set_buttons(input logic [7:0] v);
    buttons = v;
    cyc(DEB + 4);
    checks++;
    if (pad_state !== exp_state) begin
      errors++;
      $display("FAIL pad_state_settle: got %h want %h", pad_state, exp_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    buttons = 8'h00;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if (pad_data !== 1'b1) begin errors++; $display("FAIL reset_pad_data: got %b want 1", pad_data); end
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++;
    if (pad_state !== 8'h00) begin errors++; $display("FAIL reset_pad_state: got %h want 00", pad_state); end
  endtask

  task automatic test_frame(input logic [7:0] pat);
    int fd0;
    set_buttons(pat);
    strobe_pulse();
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL frame_start_count: got %0d want 0", bit_count); end
    fd0 = fd_count;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pad_data !== ~exp_state[i]) begin
        errors++;
        $display("FAIL frame_bit%0d (pat %h): got %b want %b", i, pat, pad_data, ~exp_state[i]);
      end
      clk_pulse();
    end
    checks++;
    if (bit_count !== 4'd8) begin errors++; $display("FAIL frame_end_count: got %0d want 8", bit_count); end
    checks++;
    if (fd_count !== fd0 + 1) begin errors++; $display("FAIL frame_done_once: got %0d pulses want 1", fd_count - fd0); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pad_data !== 1'b0) begin errors++; $display("FAIL frame_tail%0d_data: got %b want 0", i, pad_data); end
      clk_pulse();
    end
    checks++;
    if (pad_data !== 1'b0 || bit_count !== 4'd8 || fd_count !== fd0 + 1) begin
      errors++;
      $display("FAIL frame_extra_clocks: data %b count %0d pulses %0d want 0/8/1",
               pad_data, bit_count, fd_count - fd0);
    end
  endtask

  task automatic test_glitch();
    int g;
    set_buttons(8'b0000_0001);
    strobe_pulse();
    g = $urandom_range(1, FILT - 1);
    pad_clock = 1'b1;
    cyc(g);
    pad_clock = 1'b0;
    cyc(SETTLE);
    checks++;
    if (bit_count !== 4'd0 || pad_data !== 1'b0) begin
      errors++;
      $display("FAIL glitch_short(%0d): count %0d data %b want 0/0", g, bit_count, pad_data);
    end
    pad_clock = 1'b1;
    cyc(FILT);
    pad_clock = 1'b0;
    cyc(SETTLE);
    checks++;
    if (bit_count !== 4'd1 || pad_data !== 1'b1) begin
      errors++;
      $display("FAIL glitch_exact: count %0d data %b want 1/1", bit_count, pad_data);
    end
  endtask

  task automatic test_latency();
    strobe_pulse();
    pad_clock = 1'b1;
    cyc(FILT + 2);
    checks++;
    if (pad_data !== 1'b0) begin errors++; $display("FAIL latency_early: got %b want 0", pad_data); end
    cyc(1);
    checks++;
    if (pad_data !== 1'b1) begin errors++; $display("FAIL latency_exact: got %b want 1", pad_data); end
    pad_clock = 1'b0;
    cyc(SETTLE);
  endtask

  task automatic test_abort();
    int fd0;
    set_buttons(8'($urandom));
    fd0 = fd_count;
    strobe_pulse();
    repeat (3) clk_pulse();
    checks++;
    if (bit_count !== 4'd3) begin errors++; $display("FAIL abort_pre_count: got %0d want 3", bit_count); end
    pad_strobe = 1'b1;
    cyc(SETTLE);
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", bit_count); end
    checks++;
    if (pad_data !== ~exp_state[0]) begin errors++; $display("FAIL abort_data: got %b want %b", pad_data, ~exp_state[0]); end
    pad_strobe = 1'b0;
    cyc(SETTLE);
    repeat (7) clk_pulse();
    checks++;
    if (fd_count !== fd0 || bit_count !== 4'd7) begin
      errors++;
      $display("FAIL abort_no_pulse: pulses %0d count %0d want 0/7", fd_count - fd0, bit_count);
    end
    clk_pulse();
    checks++;
    if (fd_count !== fd0 + 1) begin errors++; $display("FAIL abort_new_frame: pulses %0d want 1", fd_count - fd0); end
  endtask

  task automatic test_priority();
    set_buttons(8'b0000_0010);
    pad_strobe = 1'b1;
    cyc(SETTLE);
    pad_strobe = 1'b0;
    pad_clock = 1'b1;
    cyc(SETTLE);
    checks++;
    if (bit_count !== 4'd0 || pad_data !== 1'b1) begin
      errors++;
      $display("FAIL priority_discard: count %0d data %b want 0/1", bit_count, pad_data);
    end
    pad_clock = 1'b0;
    cyc(SETTLE);
    clk_pulse();
    checks++;
    if (bit_count !== 4'd1 || pad_data !== 1'b0) begin
      errors++;
      $display("FAIL priority_next_shift: count %0d data %b want 1/0", bit_count, pad_data);
    end
  endtask

  task automatic test_bounce();
    set_buttons(8'h02);
    for (int i = 0; i < 9; i++) begin
      buttons[5] = ~buttons[5];
      cyc(3);
      checks++;
      if (pad_state !== exp_state || pad_state !== 8'h02) begin
        errors++;
        $display("FAIL bounce_%0d: got %h want %h", i, pad_state, exp_state);
      end
    end
    cyc(DEB - 2);
    checks++;
    if (pad_state !== 8'h02) begin errors++; $display("FAIL bounce_early: got %h want 02", pad_state); end
    cyc(1);
    checks++;
    if (pad_state !== 8'h22 || exp_state !== 8'h22) begin
      errors++;
      $display("FAIL bounce_settle: got %h model %h want 22", pad_state, exp_state);
    end
  endtask

  task automatic test_reset_mid();
    strobe_pulse();
    repeat (3) clk_pulse();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pad_data !== 1'b1 || bit_count !== 4'd0 || frame_done !== 1'b0 || pad_state !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: data %b count %0d done %b state %h want 1/0/0/00",
               pad_data, bit_count, frame_done, pad_state);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(DEB + 4);
    checks++;
    if (pad_state !== exp_state || pad_state !== buttons) begin
      errors++;
      $display("FAIL reset_relearn: got %h want %h", pad_state, exp_state);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'b1000_1001);
    test_glitch();
    test_latency();
    test_abort();
    test_priority();
    test_bounce();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_frame(8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
